twiddle_gen: RTL and testbench
==============================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 The block SHALL have parameter LOG2N, default 7, meaning log2 of the FFT size N, legal range 3..12.
REQ-002 The block SHALL have parameter TW_W, default 16, meaning the signed two's-complement twiddle output width.
REQ-003 The block SHALL have parameter ZERO_AT_0, default 1, meaning that address 0 outputs 0+j0 (multiply bypass marker) instead of 1+j0.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clock  in  1  master clock; all state on rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  single-address request valid.
- in_ready  out  1  single request accepted when in_valid&&in_ready.
- in_addr  in  LOG2N  twiddle index n.
- in_inv  in  1  1 = conjugate output (inverse FFT).
- seq_start  in  1  start an auto-address sequence.
- seq_step  in  LOG2N  address increment per sequence element.
- seq_count  in  LOG2N+1  number of sequence elements, 0..N.
- seq_inv  in  1  conjugate flag for the whole sequence.
- seq_busy  out  1  sequencer in RUN.
- out_valid  out  1  output twiddle valid.
- out_ready  in  1  downstream accepts the output.
- out_re  out  TW_W  cos(-2*pi*n/N), scaled.
- out_im  out  TW_W  sin(-2*pi*n/N), scaled; negated when inverse.
- out_last  out  1  marks the final sequence element.

Function
REQ-005 Scaling SHALL be round(x*2^(TW_W-1)), with +1.0 clamped to 2^(TW_W-1)-1 and -1.0 output exactly as -2^(TW_W-1).
REQ-006 Storage SHALL be a quarter-wave unsigned magnitude table M[k]=round(cos(2*pi*k/N)*2^(TW_W-1)), k=0..N/4, generated at elaboration, with no full-period table.
REQ-007 Folding SHALL use q=n[LOG2N-1:LOG2N-2], r=n mod N/4, C=M[r], S=M[N/4-r], giving q0: (C,-S), q1: (-S,-C), q2: (-C,S), q3: (S,-C negated, i.e. +C) as (re,im).
REQ-008 Positive results SHALL be clamped per REQ-005, and inverse mode SHALL negate the final im with the same clamp rule.
REQ-009 With ZERO_AT_0=1 and n=0, the output SHALL be 0,0 regardless of the inverse flag.
REQ-010 The pipeline SHALL have 2 stages (S1: fold and table read; S2: sign, swap and clamp), with the output registered.
REQ-011 Latency SHALL be 2 cycles, so a request accepted at edge k appears with out_valid=1 after edge k+2 when out_ready stays high.
REQ-012 The pipeline SHALL use a global enable en = out_ready || !out_valid, and when en=0 all stages, the sequencer and the outputs SHALL hold.
REQ-013 out_re, out_im and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Throughput SHALL be one twiddle per cycle when out_ready=1.
REQ-015 The FSM SHALL have states IDLE and RUN, with seq_busy=1 only in RUN.
REQ-016 in_ready SHALL equal en && IDLE && !seq_start.
REQ-017 In IDLE, seq_start with en=1 and seq_count>0 SHALL latch step, count and inv, set acc=0, and move to RUN.
REQ-018 In IDLE, seq_start with seq_count=0 SHALL be ignored, with no output and the FSM staying in IDLE.
REQ-019 seq_start and in_valid in the same cycle SHALL resolve in favour of seq_start, and the single request SHALL NOT be accepted.
REQ-020 In RUN, each en cycle SHALL issue address acc with acc <= (acc+step) mod N (wraps), and the element counter SHALL decrement.
REQ-021 The final element SHALL carry last=1, after which the FSM returns to IDLE in the same cycle it issues that element.
REQ-022 seq_start in RUN SHALL be ignored.
REQ-023 out_last SHALL be 0 for single requests, and last SHALL travel with its data through the pipeline.

Reset
REQ-024 When reset_n=0 at a clock edge, the block SHALL set out_valid=0, out_re=0, out_im=0, out_last=0, all stage valids=0, FSM=IDLE, seq_busy=0, acc=0 and counter=0.
REQ-025 Reset mid-sequence or mid-stall SHALL abort all in-flight data, and no output SHALL appear after reset deassertion until a new request.
REQ-026 in_ready SHALL be 0 while reset_n=0.

Verification (LOG2N=7, TW_W=16, ZERO_AT_0=1)
REQ-027 Single requests SHALL give: n=1 -> 7FD9/F9B8 two cycles later; n=32 -> 0000/8000; n=64 -> 8000/0000; n=96 -> 0000/7FFF; n=0 -> 0000/0000 (ZERO_AT_0=0: 7FFF/0000).
REQ-028 Inverse mode with n=1, in_inv=1 SHALL give 7FD9/0648, and n=32, in_inv=1 SHALL give 0000/7FFF.
REQ-029 seq_start with step=3, count=4 SHALL give addresses 0,3,6,9 (0000/0000, 7E9D/ED38, 7A7D/DAD8, 73B6/C946) on consecutive cycles, out_last on the 4th, and seq_busy high for 4 cycles.
REQ-030 Wrap case: step=100, count=3 SHALL give addresses 0,100,72 (the last being 89BE/30FC).
REQ-031 Stall: holding out_ready=0 for 5 cycles mid-sequence SHALL keep outputs frozen, lose and duplicate no elements, and give in_ready=0.
REQ-032 Corner cases: seq_start with in_valid in IDLE -> sequence runs and the single request is not accepted; reset_n=0 mid-RUN -> seq_busy=0 and out_valid=0 next cycle; count=0 -> no activity.

Source files
------------

// File: rtl/twiddle_gen_if.sv
// Handshake bundle for twiddle_gen: single-address request port, sequencer
// controls and the twiddle output stream.
interface twiddle_gen_if #(
  parameter int LOG2N = 7,
  parameter int TW_W  = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LOG2N-1:0]       in_addr;
  logic                   in_inv;
  logic                   seq_start;
  logic [LOG2N-1:0]       seq_step;
  logic [LOG2N:0]         seq_count;
  logic                   seq_inv;
  logic                   seq_busy;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [TW_W-1:0] out_re;
  logic signed [TW_W-1:0] out_im;
  logic                   out_last;

  modport master (
    output in_valid, in_addr, in_inv, seq_start, seq_step, seq_count, seq_inv, out_ready,
    input  in_ready, seq_busy, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_addr, in_inv, seq_start, seq_step, seq_count, seq_inv, out_ready,
    output in_ready, seq_busy, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/twiddle_gen.sv
// FFT twiddle factor generator: quarter-wave magnitude table folded into all
// four quadrants, single-address port plus an auto-stepping sequencer.
module twiddle_gen #(
  parameter int LOG2N     = 7,
  parameter int TW_W      = 16,
  parameter bit ZERO_AT_0 = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  twiddle_gen_if.slave  tw
);
  localparam int  N  = 1 << LOG2N;
  localparam int  QN = N / 4;
  localparam int  QW = LOG2N - 2;
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [TW_W:0] POS_MAX = (TW_W+1)'((1 << (TW_W-1)) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [TW_W-1:0] mag_of(input int k);
    real x;
    x = $cos(2.0 * PI * real'(k) / real'(N)) * real'(1 << (TW_W-1));
    return TW_W'($rtoi(x + 0.5));
  endfunction

  // Only +1.0 can overflow; -1.0 is representable exactly.
  function automatic logic signed [TW_W-1:0] sat(input logic signed [TW_W:0] v);
    if (v > POS_MAX) return POS_MAX[TW_W-1:0];
    return v[TW_W-1:0];
  endfunction

  logic [TW_W-1:0] rom [0:QN];
  for (genvar k = 0; k <= QN; k++) begin : g_rom
    assign rom[k] = mag_of(k);
  end

  state_t           state;
  logic             en, start_ok, take_single, issue;
  logic [LOG2N-1:0] acc, step_r;
  logic [LOG2N:0]   cnt;
  logic             sinv_r;

  logic             vld_p0, vld_p1;
  logic [LOG2N-1:0] addr_p0;
  logic             inv_p0, last_p0;
  logic [TW_W-1:0]  c_p1, s_p1;
  logic [1:0]       q_p1;
  logic             inv_p1, last_p1, zero_p1;

  logic [QW:0]      r_idx, r_mirror;
  logic signed [TW_W:0] c_s, s_s, re_v, im_v;

  assign en          = tw.out_ready || !tw.out_valid;
  assign tw.in_ready = reset_n && en && (state == IDLE) && !tw.seq_start;
  assign start_ok    = (state == IDLE) && tw.seq_start && (tw.seq_count != '0);
  assign take_single = tw.in_ready && tw.in_valid;
  assign issue       = (state == RUN);

  assign r_idx    = {1'b0, addr_p0[QW-1:0]};
  assign r_mirror = (QW+1)'(QN) - r_idx;

  always_comb begin
    c_s  = signed'({1'b0, c_p1});
    s_s  = signed'({1'b0, s_p1});
    re_v = c_s;
    im_v = -s_s;
    case (q_p1)
      2'd0:    begin re_v = c_s;  im_v = -s_s; end
      2'd1:    begin re_v = -s_s; im_v = -c_s; end
      2'd2:    begin re_v = -c_s; im_v = s_s;  end
      default: begin re_v = s_s;  im_v = c_s;  end
    endcase
    if (inv_p1) im_v = -im_v;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      tw.seq_busy  <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      tw.out_valid <= 1'b0;
      tw.out_re    <= '0;
      tw.out_im    <= '0;
      tw.out_last  <= 1'b0;
    end else if (en) begin
      vld_p0       <= take_single || issue;
      vld_p1       <= vld_p0;
      tw.out_valid <= vld_p1;
      tw.out_re    <= zero_p1 ? '0 : sat(re_v);
      tw.out_im    <= zero_p1 ? '0 : sat(im_v);
      tw.out_last  <= last_p1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= RUN;
            tw.seq_busy <= 1'b1;
            acc         <= '0;
            cnt         <= tw.seq_count;
          end
        end
        RUN: begin
          acc <= acc + step_r;
          cnt <= cnt - (LOG2N+1)'(1);
          if (cnt == (LOG2N+1)'(1)) begin
            state       <= IDLE;
            tw.seq_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: request capture (single port or sequencer address)
  always_ff @(posedge clock) begin
    if (en) begin
      if (state == IDLE) begin
        if (start_ok) begin
          step_r <= tw.seq_step;
          sinv_r <= tw.seq_inv;
        end
        addr_p0 <= tw.in_addr;
        inv_p0  <= tw.in_inv;
        last_p0 <= 1'b0;
      end else begin
        addr_p0 <= acc;
        inv_p0  <= sinv_r;
        last_p0 <= (cnt == (LOG2N+1)'(1));
      end
      // p1: quadrant fold and table read
      c_p1    <= rom[r_idx];
      s_p1    <= rom[r_mirror];
      q_p1    <= addr_p0[LOG2N-1 -: 2];
      inv_p1  <= inv_p0;
      last_p1 <= last_p0;
      zero_p1 <= ZERO_AT_0 && (addr_p0 == '0);
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen (LOG2N=7, TW_W=16); a second instance with
// ZERO_AT_0=0 shadows the same stimulus for the address-0 case.
module tb_twiddle_gen;
  localparam int  LOG2N = 7;
  localparam int  TW_W  = 16;
  localparam int  N     = 1 << LOG2N;
  localparam real PI    = 3.14159265358979323846;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  bit   bp_en   = 1'b0;
  bit   rdy_force = 1'b1;
  logic [32:0] exp_q[$];

  int          vec_n   [6] = '{32, 64, 96, 1, 32, 0};
  bit          vec_inv [6] = '{0, 0, 0, 1, 1, 1};
  logic [31:0] vec_exp [6] = '{32'h0000_8000, 32'h8000_0000, 32'h0000_7FFF,
                               32'h7FD9_0648, 32'h0000_7FFF, 32'h0000_0000};

  always #5 clock = ~clock;

  twiddle_gen_if #(.LOG2N(LOG2N), .TW_W(TW_W)) tw ();
  twiddle_gen_if #(.LOG2N(LOG2N), .TW_W(TW_W)) tz ();

  twiddle_gen #(.LOG2N(LOG2N), .TW_W(TW_W), .ZERO_AT_0(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .tw(tw));
  twiddle_gen #(.LOG2N(LOG2N), .TW_W(TW_W), .ZERO_AT_0(1'b0)) dut_nz (
    .clock(clock), .reset_n(reset_n), .tw(tz));

  assign tz.in_valid  = tw.in_valid;
  assign tz.in_addr   = tw.in_addr;
  assign tz.in_inv    = tw.in_inv;
  assign tz.seq_start = tw.seq_start;
  assign tz.seq_step  = tw.seq_step;
  assign tz.seq_count = tw.seq_count;
  assign tz.seq_inv   = tw.seq_inv;
  assign tz.out_ready = tw.out_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Direct full-angle reference: re=cos(-a), im=sin(-a), conjugate on inverse.
  function automatic logic [32:0] model(input int n, input bit inv, input bit last);
    real a;
    int  re, im;
    if (n == 0) return {last, 32'h0};
    a  = 2.0 * PI * real'(n) / real'(N);
    re = rnd($cos(a) * 32768.0);
    im = rnd(-$sin(a) * 32768.0);
    if (inv) im = -im;
    if (re > 32767) re = 32767;
    if (im > 32767) im = 32767;
    return {last, 16'(re), 16'(im)};
  endfunction

  task automatic send(input int n, input bit inv, input logic [32:0] e, output int waited);
    tw.in_valid = 1'b1;
    tw.in_addr  = LOG2N'(n);
    tw.in_inv   = inv;
    waited = 0;
    @(negedge clock);
    while (!tw.in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("in_ready", tw.in_ready, 1'b1);
    if (tw.in_ready) exp_q.push_back(e);
    @(posedge clock); #1;
    tw.in_valid = 1'b0;
  endtask

  task automatic push_seq(input int step, input int count, input bit inv);
    for (int i = 0; i < count; i++)
      exp_q.push_back(model((i * step) % N, inv, i == count - 1));
  endtask

  task automatic seq(input int step, input int count, input bit inv, input bit with_single);
    tw.seq_start = 1'b1;
    tw.seq_step  = LOG2N'(step);
    tw.seq_count = (LOG2N+1)'(count);
    tw.seq_inv   = inv;
    if (with_single) begin
      tw.in_valid = 1'b1;
      tw.in_addr  = 7'd5;
      tw.in_inv   = 1'b0;
    end
    @(negedge clock);
    check("start_in_ready", tw.in_ready, 1'b0);
    @(posedge clock); #1;
    tw.seq_start = 1'b0;
    tw.in_valid  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Output monitor: every accepted beat is checked against the queue head.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && tw.out_valid && tw.out_ready) begin
        if (exp_q.size() == 0) check("extra_out", tw.out_valid, 1'b0);
        else check("sb_data", {tw.out_last, tw.out_re, tw.out_im}, exp_q.pop_front());
      end
    end
  end

  initial begin
    tw.out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      tw.out_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, busy, nv, first, lastv, rn;
    bit ri;
    tw.in_valid = 1'b0; tw.in_addr = '0; tw.in_inv = 1'b0;
    tw.seq_start = 1'b0; tw.seq_step = '0; tw.seq_count = '0; tw.seq_inv = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", tw.in_ready, 1'b0);
    check("rst_out_valid", tw.out_valid, 1'b0);
    check("rst_out_data", {tw.out_last, tw.out_re, tw.out_im}, 33'h0);
    check("rst_busy", tw.seq_busy, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Latency: accepted at edge k, valid after edge k+2
    send(1, 1'b0, {1'b0, 32'h7FD9_F9B8}, w);
    @(negedge clock); check("lat_k0", tw.out_valid, 1'b0);
    @(negedge clock); check("lat_k1", tw.out_valid, 1'b0);
    @(negedge clock); check("lat_k2", tw.out_valid, 1'b1);
    drain();

    for (int i = 0; i < 6; i++) send(vec_n[i], vec_inv[i], {1'b0, vec_exp[i]}, w);
    drain();

    send(0, 1'b0, 33'h0, w);
    repeat (3) @(negedge clock);
    check("nz_valid", tz.out_valid, 1'b1);
    check("nz_data", {tz.out_re, tz.out_im}, 32'h7FFF_0000);
    drain();

    for (int i = 0; i < 16; i++) begin
      rn = int'($urandom_range(0, N - 1));
      ri = 1'($urandom_range(0, 1));
      send(rn, ri, model(rn, ri, 1'b0), w);
      check("tput_wait", w, 0);
    end
    drain();

    bp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rn = int'($urandom_range(0, N - 1));
      ri = 1'($urandom_range(0, 1));
      send(rn, ri, model(rn, ri, 1'b0), w);
    end
    bp_en = 1'b0;
    drain();

    exp_q.push_back({1'b0, 32'h0000_0000});
    exp_q.push_back({1'b0, 32'h7E9D_ED38});
    exp_q.push_back({1'b0, 32'h7A7D_DAD8});
    exp_q.push_back({1'b1, 32'h73B6_C946});
    seq(3, 4, 1'b0, 1'b0);
    busy = 0; nv = 0; first = -1; lastv = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (tw.seq_busy) busy++;
      if (tw.out_valid) begin
        nv++;
        if (first < 0) first = i;
        lastv = i;
      end
    end
    check("seq_busy_cycles", busy, 4);
    check("seq_valids", nv, 4);
    check("seq_span", lastv - first, 3);
    drain();

    // Wrap, with a competing single request that must lose
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back(model(100, 1'b0, 1'b0));
    exp_q.push_back({1'b1, 32'h89BE_30FC});
    seq(100, 3, 1'b0, 1'b1);
    drain();

    push_seq(1, 3, 1'b1);
    seq(1, 3, 1'b1, 1'b0);
    seq(2, 2, 1'b0, 1'b0);
    drain();
    check("run_start_ignored", tw.seq_busy, 1'b0);

    seq(5, 0, 1'b0, 1'b0);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (tw.seq_busy || tw.out_valid) nv++;
    end
    check("count0_quiet", nv, 0);
    @(posedge clock); #1;

    push_seq(5, 8, 1'b1);
    seq(5, 8, 1'b1, 1'b0);
    w = 0;
    @(negedge clock);
    while (!tw.out_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("stall_pre", tw.out_valid, 1'b1);
    rdy_force = 1'b0;
    @(posedge clock); #2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_valid", tw.out_valid, 1'b1);
      check("stall_in_ready", tw.in_ready, 1'b0);
      check("stall_busy", tw.seq_busy, 1'b1);
      if (exp_q.size() != 0)
        check("stall_data", {tw.out_last, tw.out_re, tw.out_im}, exp_q[0]);
    end
    rdy_force = 1'b1;
    drain();

    push_seq(7, 10, 1'b0);
    seq(7, 10, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_mid_in_ready", tw.in_ready, 1'b0);
    @(posedge clock); #1;
    exp_q.delete();
    @(negedge clock);
    check("rst_mid_valid", tw.out_valid, 1'b0);
    check("rst_mid_busy", tw.seq_busy, 1'b0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (tw.out_valid) nv++;
    end
    check("post_rst_quiet", nv, 0);
    @(posedge clock); #1;
    send(64, 1'b1, {1'b0, 32'h8000_0000}, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
